// File: rtl/audio_lpf_decim.sv
// rtl/audio_lpf_decim.sv - decimating audio low-pass FIR with a single sequential MAC
// Optional output saturation with a 40-bit accumulator: define AUDIO_LPF_SAT_EN.
module audio_lpf_decim #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TAPS   = 32,
    parameter int DECIMATION = 8,
    parameter int BITS       = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic [DATA_WIDTH-1:0] out_din
);

    localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int CNT_W = $clog2(DECIMATION + 1);
`ifdef AUDIO_LPF_SAT_EN
    localparam int ACC_W = 40;
`else
    localparam int ACC_W = 32;
`endif

    localparam logic signed [DATA_WIDTH-1:0] AUDIO_LPR_COEFFS [NUM_TAPS] = '{
        32'hfffffffd, 32'hfffffffa, 32'hfffffff4, 32'hffffffed,
        32'hffffffe5, 32'hffffffdf, 32'hffffffe2, 32'hfffffff3,
        32'h00000015, 32'h0000004e, 32'h0000009b, 32'h000000f9,
        32'h0000015d, 32'h000001be, 32'h0000020e, 32'h00000243,
        32'h00000243, 32'h0000020e, 32'h000001be, 32'h0000015d,
        32'h000000f9, 32'h0000009b, 32'h0000004e, 32'h00000015,
        32'hfffffff3, 32'hffffffe2, 32'hffffffdf, 32'hffffffe5,
        32'hffffffed, 32'hfffffff4, 32'hfffffffa, 32'hfffffffd
    };

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic signed [DATA_WIDTH-1:0]  x [NUM_TAPS];
    logic [CNT_W-1:0]              fill_cnt;
    logic [TAP_W-1:0]              tap;
    logic signed [ACC_W-1:0]       acc;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]       acc_next;
    logic [DATA_WIDTH-1:0]         acc_out;
    logic                          pop;
    logic                          last_pop;
    logic                          last_tap;

    assign prod     = x[tap] * AUDIO_LPR_COEFFS[tap];
    assign acc_next = acc + ACC_W'(prod >>> BITS);
    assign pop      = in_rd_en;
    assign last_pop = pop && (fill_cnt == CNT_W'(DECIMATION - 1));
    assign last_tap = (tap == TAP_W'(NUM_TAPS - 1));

`ifdef AUDIO_LPF_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(64'sh0000_0000_7fff_ffff);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-64'sh0000_0000_8000_0000);

    always_comb begin
        acc_out = acc_next[DATA_WIDTH-1:0];
        if (acc_next > SAT_MAX) begin
            acc_out = SAT_MAX[DATA_WIDTH-1:0];
        end else if (acc_next < SAT_MIN) begin
            acc_out = SAT_MIN[DATA_WIDTH-1:0];
        end
    end
`else
    assign acc_out = acc_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Reset gates the read strobe too, since the reset state is S_FILL.
    always_comb begin
        state_next = state;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        case (state)
            S_FILL: begin
                in_rd_en = !in_empty && !reset;
                if (last_pop) begin
                    state_next = S_MAC;
                end
            end
            S_MAC: begin
                if (last_tap) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                out_wr_en = !out_full;
                if (!out_full) begin
                    state_next = S_FILL;
                end
            end
            default: state_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                x[i] <= '0;
            end
            fill_cnt <= '0;
            tap      <= '0;
            acc      <= '0;
            out_din  <= '0;
        end else begin
            case (state)
                S_FILL: begin
                    if (pop) begin
                        for (int i = NUM_TAPS - 1; i > 0; i--) begin
                            x[i] <= x[i-1];
                        end
                        x[0] <= in_dout;
                        if (last_pop) begin
                            fill_cnt <= '0;
                            acc      <= '0;
                            tap      <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    acc <= acc_next;
                    tap <= tap + 1'b1;
                    // Latch the finished sum so out_din is stable for all of S_WRITE.
                    if (last_tap) begin
                        out_din <= acc_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_lpf_decim.sv
// tb/tb_audio_lpf_decim.sv - directed self-checking bench for audio_lpf_decim
module tb_audio_lpf_decim;

    logic        clk;
    logic        reset;
    logic [31:0] in_dout;
    logic        in_empty;
    logic        in_rd_en;
    logic        out_full;
    logic        out_wr_en;
    logic [31:0] out_din;

    audio_lpf_decim dut (
        .clk       (clk),
        .reset     (reset),
        .in_dout   (in_dout),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .out_full  (out_full),
        .out_wr_en (out_wr_en),
        .out_din   (out_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] q[$];
    logic [31:0] outq[$];
    bit          starve = 0;
    int          v_rd_empty = 0;
    int          v_wr_full = 0;
    int          v_both = 0;

    localparam logic [31:0] IMP_EXP [5] = '{32'hfffffff3, 32'h00000243, 32'h00000015, 32'hfffffffd, 32'h0};
    localparam logic [31:0] DC_EXP  [8] = '{-32'sd143, 32'd2260, 32'd4663, 32'd4520,
                                            32'd4520, 32'd4520, 32'd4520, 32'd4520};
`ifdef AUDIO_LPF_SAT_EN
    localparam logic [31:0] OVF_EXP [5] = '{32'hee200000, 32'h7fffffff, 32'h7fffffff, 32'h7fffffff, 32'h7fffffff};
`else
    localparam logic [31:0] OVF_EXP [5] = '{32'hee200000, 32'd444596216, 32'd1189085168, 32'd889192432, 32'd889192432};
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO models: sample DUT strobes at negedge, retire the popped word just after posedge.
    initial begin
        logic rd_s;
        in_empty = 1'b1;
        in_dout  = '0;
        forever begin
            @(negedge clk);
            rd_s = in_rd_en;
            if (in_rd_en && in_empty) v_rd_empty++;
            if (out_wr_en && out_full) v_wr_full++;
            if (in_rd_en && out_wr_en) v_both++;
            if (out_wr_en) outq.push_back(out_din);
            @(posedge clk);
            #1;
            if (rd_s && !reset && q.size() > 0) void'(q.pop_front());
            if (q.size() == 0 || (starve && $urandom_range(0, 1) == 1)) begin
                in_empty = 1'b1;
            end else begin
                in_empty = 1'b0;
                in_dout  = q[0];
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        q.delete();
        outq.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic load_impulse();
        q.push_back(32'd1024);
        for (int i = 0; i < 39; i++) q.push_back(32'd0);
    endtask

    task automatic wait_outputs(input string tag, input int n, input int bound);
        int cyc = 0;
        while (outq.size() < n && cyc < bound) begin
            @(posedge clk);
            cyc++;
        end
        check(tag, 32'(outq.size()), 32'(n));
    endtask

    task automatic check_outputs(input string tag, input int n, input logic [31:0] exp [8]);
        for (int i = 0; i < n; i++) begin
            if (i < outq.size()) check($sformatf("%s[%0d]", tag, i), outq[i], exp[i]);
        end
    endtask

    initial begin
        logic [31:0] exp8 [8];
        logic [31:0] d0;
        int rd_hi, wr_hi, chg;

        reset    = 1'b1;
        out_full = 1'b0;
        #7;
        check("reset_rd_en", {31'b0, in_rd_en}, 32'd0);
        check("reset_wr_en", {31'b0, out_wr_en}, 32'd0);
        check("reset_dout", out_din, 32'd0);
        #10 reset = 1'b0;

        // Impulse
        for (int i = 0; i < 8; i++) exp8[i] = (i < 5) ? IMP_EXP[i] : 32'd0;
        do_reset();
        load_impulse();
        wait_outputs("imp_count", 5, 400);
        check_outputs("imp", 5, exp8);

        // DC
        do_reset();
        for (int i = 0; i < 64; i++) q.push_back(32'd1024);
        wait_outputs("dc_count", 8, 600);
        check_outputs("dc", 8, DC_EXP);

        // Starvation
        do_reset();
        starve = 1;
        load_impulse();
        wait_outputs("starve_count", 5, 1500);
        check_outputs("starve", 5, exp8);
        starve = 0;

        // Back-pressure
        do_reset();
        out_full = 1'b1;
        load_impulse();
        repeat (60) @(posedge clk);
        #1;
        d0 = out_din;
        check("bp_hold_value", d0, IMP_EXP[0]);
        rd_hi = 0; wr_hi = 0; chg = 0;
        repeat (20) begin
            @(negedge clk);
            if (in_rd_en) rd_hi++;
            if (out_wr_en) wr_hi++;
            if (out_din !== d0) chg++;
        end
        check("bp_rd_en_high", 32'(rd_hi), 32'd0);
        check("bp_wr_en_high", 32'(wr_hi), 32'd0);
        check("bp_dout_changed", 32'(chg), 32'd0);
        check("bp_no_push", 32'(outq.size()), 32'd0);
        @(posedge clk);
        #1 out_full = 1'b0;
        @(negedge clk);
        check("bp_release_push", {31'b0, out_wr_en}, 32'd1);
        repeat (10) @(posedge clk);
        check("bp_push_count", 32'(outq.size()), 32'd1);
        if (outq.size() > 0) check("bp_push_value", outq[0], IMP_EXP[0]);

        // Reset in the middle of the second MAC pass
        do_reset();
        load_impulse();
        wait_outputs("rst_first", 1, 200);
        repeat (28) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_mid_dout", out_din, 32'd0);
        check("rst_mid_wr_en", {31'b0, out_wr_en}, 32'd0);
        check("rst_mid_rd_en", {31'b0, in_rd_en}, 32'd0);
        q.delete();
        outq.delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        load_impulse();
        wait_outputs("rerun_count", 5, 400);
        check_outputs("rerun", 5, exp8);

        // Overflow
        for (int i = 0; i < 8; i++) exp8[i] = (i < 5) ? OVF_EXP[i] : 32'd0;
        do_reset();
        for (int i = 0; i < 40; i++) q.push_back(32'h7fffffff);
        wait_outputs("ovf_count", 5, 400);
        check_outputs("ovf", 5, exp8);

        check("inv_rd_while_empty", 32'(v_rd_empty), 32'd0);
        check("inv_wr_while_full", 32'(v_wr_full), 32'd0);
        check("inv_rd_and_wr", 32'(v_both), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
